trap_controller: RTL

// - Sequences machine-mode traps and mret returns for the core.
// - Sits at the writeback (WB) boundary and consumes the decoder's illegal-instruction and mret flags.
// - Samples the external interrupt request, drives the CSR trap-state updates, flushes the pipeline
//   and redirects the PC to mtvec (trap) or mepc (mret).

---
 rtl/trap_controller_if.sv | 45 ++++
 rtl/trap_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/trap_controller_if.sv
// Trap controller bus: WB commit info and CSR state in,
// CSR update strobes, flush and PC redirect out.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [XLEN-1:0] wb_instruction;
    logic            wb_illegal_instr;
    logic            wb_mret;
    logic            irq_req;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;

    logic            trap_flush;
    logic            trap_busy;
    logic            trap_redirect;
    logic [XLEN-1:0] trap_redirect_pc;
    logic            trap_mepc_we;
    logic [XLEN-1:0] trap_mepc;
    logic            trap_mcause_we;
    logic [XLEN-1:0] trap_mcause;
    logic            trap_mtval_we;
    logic [XLEN-1:0] trap_mtval;
    logic            trap_mstatus_enter;
    logic            trap_mstatus_exit;

    modport master (
        output wb_valid, wb_pc, wb_instruction, wb_illegal_instr,
        output wb_mret, irq_req, csr_mtvec, csr_mepc,
        input  trap_flush, trap_busy, trap_redirect, trap_redirect_pc,
        input  trap_mepc_we, trap_mepc, trap_mcause_we, trap_mcause,
        input  trap_mtval_we, trap_mtval,
        input  trap_mstatus_enter, trap_mstatus_exit
    );

    modport slave (
        input  wb_valid, wb_pc, wb_instruction, wb_illegal_instr,
        input  wb_mret, irq_req, csr_mtvec, csr_mepc,
        output trap_flush, trap_busy, trap_redirect, trap_redirect_pc,
        output trap_mepc_we, trap_mepc, trap_mcause_we, trap_mcause,
        output trap_mtval_we, trap_mtval,
        output trap_mstatus_enter, trap_mstatus_exit
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap / mret sequencer at the WB boundary.
// IDLE -> SAVE -> JUMP_T (trap) or IDLE -> RET -> JUMP_R (mret).
module trap_controller #(
    parameter int XLEN         = 32,
    parameter bit SUPPORT_TRAP = 1'b1
) (
    input logic              clk,
    input logic              rst_b,
    trap_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RET,
        JUMP_T,
        JUMP_R
    } state_t;

    localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] ILL_CAUSE  = XLEN'(2);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    generate
        if (SUPPORT_TRAP) begin : g_trap
            state_t          state;
            logic            mepc_we;
            logic            mcause_we;
            logic            mtval_we;
            logic            enter;
            logic            leave;
            logic            redirect;
            logic [XLEN-1:0] mepc;
            logic [XLEN-1:0] mcause;
            logic [XLEN-1:0] mtval;
            logic [XLEN-1:0] held_pc;

            logic            idle;
            logic            hit;
            logic            take_trap;
            logic            take_mret;
            logic [XLEN-1:0] cause_n;
            logic [XLEN-1:0] mtval_n;
            logic [XLEN-1:0] trap_base;
            logic [XLEN-1:0] trap_target;
            logic [XLEN-1:0] ret_target;
            logic [XLEN-1:0] redirect_pc;

            // Classify the committing instruction; interrupt beats illegal beats mret
            always_comb begin
                idle      = (state == IDLE);
                hit       = idle && bus.wb_valid;
                take_trap = hit && (bus.irq_req || bus.wb_illegal_instr);
                take_mret = hit && bus.wb_mret
                            && !bus.irq_req && !bus.wb_illegal_instr;
                cause_n   = bus.irq_req ? IRQ_CAUSE : ILL_CAUSE;
                mtval_n   = bus.irq_req ? '0 : bus.wb_instruction;
            end

            // Redirect target, live CSRs sampled in the jump cycle;
            // interrupts vector off mtvec when its mode field is 1
            always_comb begin
                trap_base   = bus.csr_mtvec & ALIGN_MASK;
                trap_target = trap_base;
                if (bus.csr_mtvec[1:0] == 2'b01 && mcause[XLEN-1])
                    trap_target = trap_base
                                  + (XLEN'(mcause[XLEN-2:0]) << 2);
                ret_target  = bus.csr_mepc & ALIGN_MASK;
                redirect_pc = held_pc;
                if (state == JUMP_T)
                    redirect_pc = trap_target;
                else if (state == JUMP_R)
                    redirect_pc = ret_target;
            end

            // Sequencer with registered CSR strobes and captured trap data
            always_ff @(posedge clk) begin
                if (!rst_b) begin
                    state     <= IDLE;
                    mepc_we   <= 1'b0;
                    mcause_we <= 1'b0;
                    mtval_we  <= 1'b0;
                    enter     <= 1'b0;
                    leave     <= 1'b0;
                    redirect  <= 1'b0;
                    mepc      <= '0;
                    mcause    <= '0;
                    mtval     <= '0;
                    held_pc   <= '0;
                end else begin
                    mepc_we   <= 1'b0;
                    mcause_we <= 1'b0;
                    mtval_we  <= 1'b0;
                    enter     <= 1'b0;
                    leave     <= 1'b0;
                    redirect  <= 1'b0;
                    unique case (state)
                        IDLE: begin
                            if (take_trap) begin
                                state     <= SAVE;
                                mepc      <= bus.wb_pc;
                                mcause    <= cause_n;
                                mtval     <= mtval_n;
                                mepc_we   <= 1'b1;
                                mcause_we <= 1'b1;
                                mtval_we  <= 1'b1;
                                enter     <= 1'b1;
                            end else if (take_mret) begin
                                state <= RET;
                                leave <= 1'b1;
                            end
                        end
                        SAVE: begin
                            state    <= JUMP_T;
                            redirect <= 1'b1;
                        end
                        RET: begin
                            state    <= JUMP_R;
                            redirect <= 1'b1;
                        end
                        JUMP_T, JUMP_R: begin
                            state   <= IDLE;
                            held_pc <= redirect_pc;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end

            assign bus.trap_flush         = take_trap || take_mret || !idle;
            assign bus.trap_busy          = !idle;
            assign bus.trap_redirect      = redirect;
            assign bus.trap_redirect_pc   = redirect_pc;
            assign bus.trap_mepc_we       = mepc_we;
            assign bus.trap_mepc          = mepc;
            assign bus.trap_mcause_we     = mcause_we;
            assign bus.trap_mcause        = mcause;
            assign bus.trap_mtval_we      = mtval_we;
            assign bus.trap_mtval         = mtval;
            assign bus.trap_mstatus_enter = enter;
            assign bus.trap_mstatus_exit  = leave;
        end else begin : g_none
            assign bus.trap_flush         = 1'b0;
            assign bus.trap_busy          = 1'b0;
            assign bus.trap_redirect      = 1'b0;
            assign bus.trap_redirect_pc   = '0;
            assign bus.trap_mepc_we       = 1'b0;
            assign bus.trap_mepc          = '0;
            assign bus.trap_mcause_we     = 1'b0;
            assign bus.trap_mcause        = '0;
            assign bus.trap_mtval_we      = 1'b0;
            assign bus.trap_mtval         = '0;
            assign bus.trap_mstatus_enter = 1'b0;
            assign bus.trap_mstatus_exit  = 1'b0;
        end
    endgenerate

endmodule
